mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- Memory stage of the ARM pipeline. Sits directly downstream of the EXE stage register and consumes its wb_en / mem_r_en / mem_w_en / alu_result / val_rm / dest.
- Performs 32-bit loads and stores against an external 16-bit asynchronous SRAM, as two half-word accesses with programmable wait states.
- Drives ready low to freeze all upstream pipeline registers until the access completes, then hands results to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles held per half-word access (0..15).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- wb_en_in  in  1  writeback enable from the EXE stage register.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- alu_result_in  in  32  effective byte address, or ALU result for non-memory instructions.
- val_rm_in  in  32  store data.
- dest_in  in  4  destination register.
- wb_en_out  out  1  combinational pass-through of wb_en_in.
- mem_r_en_out  out  1  combinational pass-through of mem_r_en_in.
- alu_result_out  out  32  combinational pass-through of alu_result_in.
- dest_out  out  4  combinational pass-through of dest_in.
- mem_result  out  32  registered load data.
- ready  out  1  stage complete; upstream freeze = ~ready.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq  inout  16  SRAM data bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Address mapping:
  - off = alu_result_in - BASE_ADDR, 32-bit wrap.
  - Word index w = off[SRAM_AW:2]; higher bits are truncated, so out-of-range addresses alias.
  - Low half is at sram_addr = {w,0}, high half at {w,1}.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit wait counter cnt is used within each state.
- ready is combinational:
  - 1 when neither mem_r_en_in nor mem_w_en_in is set, or when state == DONE.
  - 0 otherwise.
- IDLE:
  - Store request (mem_w_en_in) goes to WR_LO. If both enables are set, the store wins.
  - Load request goes to RD_LO.
  - Otherwise stay in IDLE.
  - Clear cnt on entry to every access state.
- RD_LO / RD_HI:
  - sram_dq is high-Z and sram_we_n = 1.
  - Increment cnt each cycle.
  - When cnt == WAIT_CYCLES, sample sram_dq into mem_result[15:0] (LO) or mem_result[31:16] (HI), then advance LO to HI and HI to DONE.
- WR_LO / WR_HI:
  - Drive sram_dq with val_rm_in[15:0] (LO) or val_rm_in[31:16] (HI).
  - sram_we_n = 0 while cnt < WAIT_CYCLES, and 1 on the cnt == WAIT_CYCLES cycle, which is a data-hold cycle.
  - Advance LO to HI and HI to DONE on cnt == WAIT_CYCLES.
- DONE:
  - Hold for one cycle with ready = 1; the pipeline advances on this edge.
  - Always return to IDLE. A new request present in the next cycle starts a fresh access.
- Latency, request first seen in IDLE at cycle 0: ready is low for 2*(WAIT_CYCLES+1)+1 cycles and high in the following cycle. With WAIT_CYCLES=1 that is low for cycles 0-4 and high at cycle 5.
- Inputs are held stable by the freeze for the whole access; the block does not latch them.
- sram_addr:
  - {w,0} in IDLE, RD_LO and WR_LO.
  - {w,1} in RD_HI, WR_HI and DONE.
- sram_dq is high-Z in every state other than WR_*.
- Reset (rst=0) at any time, including mid-access:
  - state=IDLE, cnt=0, mem_result=0, sram_we_n=1, sram_dq high-Z.
  - An interrupted store may leave one half written; this is accepted.
- mem_result holds its value until the next load overwrites it. Stores do not change it.

Optional Feature:
- Macro: SRAM_LAST_WORD_CACHE_EN.
- Defined:
  - Add a one-entry cache: valid bit, word tag w, and 32-bit data.
  - Any completed store sets the entry to {w, val_rm_in} and marks it valid.
  - Any completed load sets the entry to {w, mem_result} and marks it valid.
  - A load in IDLE that hits (valid and tag == w) loads the cached data into mem_result and goes straight to DONE. This gives 1 cycle of ready low and no SRAM cycle.
  - Reset clears valid.
- Undefined: no cache storage exists, and every load takes the full SRAM sequence.

Test Plan:
All scenarios use default parameters unless stated.
1. Store 0xDEADBEEF to 1028: sram_addr 2 with dq=0xBEEF and we_n low 1 cycle, then addr 3 with dq=0xDEAD; ready low cycles 0-4, high cycle 5.
2. Load from 1028 after scenario 1, with the SRAM model: mem_result = 0xDEADBEEF at cycle 5; ready low 5 cycles; we_n stays 1.
3. Non-memory instruction (alu_result_in=0x12, wb_en_in=1, both mem enables 0): ready stays 1, outputs pass through, FSM stays IDLE, dq high-Z.
4. WAIT_CYCLES=3, load from 1024: ready low for exactly 9 cycles, and each half is sampled on its 4th cycle.
5. Assert rst=0 during WR_HI: we_n goes to 1 and dq to high-Z immediately, state=IDLE, mem_result=0; after release, a fresh store completes normally.
6. With SRAM_LAST_WORD_CACHE_EN, store 0x0000CAFE to 1032, then load from 1032: ready low 1 cycle, mem_result=0x0000CAFE, no SRAM read strobe; a load from 1036 takes the full 5 cycles.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_sram_ctrl_if                                       |
// | Description : Pipeline-side bundle of the memory stage. The EXE stage      |
// |               register drives the *_in signals. The memory stage returns   |
// |               the pass-throughs, the load data and the ready/freeze flag.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_stage_sram_ctrl_if;
   logic        wb_en_in;
   logic        mem_r_en_in;
   logic        mem_w_en_in;
   logic [31:0] alu_result_in;
   logic [31:0] val_rm_in;
   logic [3:0]  dest_in;
   logic        wb_en_out;
   logic        mem_r_en_out;
   logic [31:0] alu_result_out;
   logic [3:0]  dest_out;
   logic [31:0] mem_result;
   logic        ready;

   // Upstream side: the EXE stage register, or a testbench standing in for it
   modport master (
      output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in,
      input  wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_result, ready
   );

   // Memory stage side
   modport slave (
      input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in,
      output wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_result, ready
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_sram_ctrl                                          |
// | Description : ARM pipeline memory stage. It performs a 32-bit load or      |
// |               store as two half-word accesses to an external 16-bit async  |
// |               SRAM, with WAIT_CYCLES extra cycles per half. ready is held  |
// |               low to freeze the upstream registers until the access ends.  |
// | Options     : `define SRAM_LAST_WORD_CACHE_EN adds a one-entry last-word   |
// |               cache. A load that hits the cache completes without an SRAM  |
// |               access.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage_sram_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned SRAM_AW     = 18
) (
   input  wire logic             clk,
   input  wire logic             rst,       // asynchronous, active low
   mem_stage_sram_ctrl_if.slave  bus,
   output logic [SRAM_AW-1:0]    sram_addr,
   inout  wire  [15:0]           sram_dq,
   output logic                  sram_we_n
);

   localparam int unsigned c_word_w    = SRAM_AW - 1;
   localparam logic [31:0] c_base_addr = 32'(BASE_ADDR);
   localparam logic [3:0]  c_wait      = 4'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_next;
   logic                w_cnt_done;
   logic [c_word_w-1:0] w_word;
   logic                w_addr_hi;
   logic                w_drive;
   logic [15:0]         w_dq_out;
   logic                w_we_n;
   logic                w_ld_lo;
   logic                w_ld_hi;
   logic                w_ld_hit;
   logic                w_hit;
   logic [31:0]         w_cache_data;
   logic [31:0]         r_mem_result;

   // The word index is the byte offset from BASE_ADDR divided by four.
   // Offset bits above the SRAM range are dropped, so out-of-range addresses alias.
   assign w_word     = c_word_w'((bus.alu_result_in - c_base_addr) >> 2);
   assign w_cnt_done = (r_cnt == c_wait);

   // State and wait counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state, counter, SRAM strobes and load-data capture enables
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + 4'd1;
      w_addr_hi    = 1'b0;
      w_drive      = 1'b0;
      w_dq_out     = 16'h0000;
      w_we_n       = 1'b1;
      w_ld_lo      = 1'b0;
      w_ld_hi      = 1'b0;
      w_ld_hit     = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = 4'd0;
            if (bus.mem_w_en_in) begin
               w_state_next = WR_LO;              // store wins over load
            end else if (bus.mem_r_en_in) begin
               if (w_hit) begin
                  w_state_next = DONE;
                  w_ld_hit     = 1'b1;
               end else begin
                  w_state_next = RD_LO;
               end
            end
         end
         RD_LO: begin
            if (w_cnt_done) begin
               w_ld_lo      = 1'b1;
               w_state_next = RD_HI;
               w_cnt_next   = 4'd0;
            end
         end
         RD_HI: begin
            w_addr_hi = 1'b1;
            if (w_cnt_done) begin
               w_ld_hi      = 1'b1;
               w_state_next = DONE;
               w_cnt_next   = 4'd0;
            end
         end
         WR_LO: begin
            w_drive  = 1'b1;
            w_dq_out = bus.val_rm_in[15:0];
            w_we_n   = w_cnt_done;                // last cycle holds data with the strobe released
            if (w_cnt_done) begin
               w_state_next = WR_HI;
               w_cnt_next   = 4'd0;
            end
         end
         WR_HI: begin
            w_addr_hi = 1'b1;
            w_drive   = 1'b1;
            w_dq_out  = bus.val_rm_in[31:16];
            w_we_n    = w_cnt_done;
            if (w_cnt_done) begin
               w_state_next = DONE;
               w_cnt_next   = 4'd0;
            end
         end
         DONE: begin
            w_addr_hi    = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = 4'd0;
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = 4'd0;
         end
      endcase
   end

   // Load result register: each half is captured on the last cycle of its access
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_result <= 32'h0;
      end else if (w_ld_hit) begin
         r_mem_result <= w_cache_data;
      end else begin
         if (w_ld_lo) r_mem_result[15:0]  <= sram_dq;
         if (w_ld_hi) r_mem_result[31:16] <= sram_dq;
      end
   end

`ifdef SRAM_LAST_WORD_CACHE_EN
   logic                r_c_valid;
   logic [c_word_w-1:0] r_c_tag;
   logic [31:0]         r_c_data;

   // Last-word cache: refreshed by every completed store or SRAM load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c_valid <= 1'b0;
         r_c_tag   <= '0;
         r_c_data  <= 32'h0;
      end else if (r_state == WR_HI && w_cnt_done) begin
         r_c_valid <= 1'b1;
         r_c_tag   <= w_word;
         r_c_data  <= bus.val_rm_in;
      end else if (w_ld_hi) begin
         r_c_valid <= 1'b1;
         r_c_tag   <= w_word;
         r_c_data  <= {sram_dq, r_mem_result[15:0]};
      end
   end

   assign w_hit        = r_c_valid && (r_c_tag == w_word);
   assign w_cache_data = r_c_data;
`else
   assign w_hit        = 1'b0;
   assign w_cache_data = 32'h0;
`endif

   // SRAM pins: the bus is released in every state except the write states
   assign sram_addr = {w_word, w_addr_hi};
   assign sram_we_n = w_we_n;
   assign sram_dq   = w_drive ? w_dq_out : 16'hzzzz;

   // Pipeline outputs. A memory request freezes upstream until DONE.
   assign bus.ready          = !(bus.mem_r_en_in || bus.mem_w_en_in) || (r_state == DONE);
   assign bus.mem_result     = r_mem_result;
   assign bus.wb_en_out      = bus.wb_en_in;
   assign bus.mem_r_en_out   = bus.mem_r_en_in;
   assign bus.alu_result_out = bus.alu_result_in;
   assign bus.dest_out       = bus.dest_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage_sram_ctrl                                       |
// | Description : Directed self-checking bench for mem_stage_sram_ctrl. Load   |
// |               results go through an expected-value queue. Honours          |
// |               SRAM_LAST_WORD_CACHE_EN for the cache-hit scenario.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage_sram_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q [$];

   // ---------------- DUT with default parameters and a 64-entry SRAM model
   mem_stage_sram_ctrl_if bus0 ();
   logic [17:0] sram_addr0;
   wire  [15:0] sram_dq0;
   logic        sram_we_n0;
   logic [15:0] mem0 [0:63];
   logic        sram_oe0;
   logic        mem_init;
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [15:0] poke_val;

   mem_stage_sram_ctrl u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .sram_addr (sram_addr0),
      .sram_dq   (sram_dq0),
      .sram_we_n (sram_we_n0)
   );

   assign sram_dq0 = sram_oe0 ? mem0[sram_addr0[5:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem0[i] <= 16'h5A00 + 16'(i);
      end else if (poke_en) begin
         mem0[poke_idx] <= poke_val;
      end else if (!sram_we_n0) begin
         mem0[sram_addr0[5:0]] <= sram_dq0;
      end
   end

   // ---------------- DUT with WAIT_CYCLES = 3; the bench drives its data bus directly
   mem_stage_sram_ctrl_if bus3 ();
   logic [17:0] sram_addr3;
   wire  [15:0] sram_dq3;
   logic        sram_we_n3;
   logic [15:0] dq3_val;

   mem_stage_sram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus3),
      .sram_addr (sram_addr3),
      .sram_dq   (sram_dq3),
      .sram_we_n (sram_we_n3)
   );

   assign sram_dq3 = dq3_val;

   // ---------------- helpers
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] exp_addr(input logic [31:0] a, input logic hi);
      return {17'((a - 32'd1024) >> 2), hi};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      bus0.mem_r_en_in = 1'b0;
      bus0.mem_w_en_in = 1'b0;
      bus0.wb_en_in    = 1'b0;
      sram_oe0         = 1'b1;
   endtask

   // One full SRAM access on dut0 (WAIT_CYCLES=1). Cycle 0 is the IDLE cycle
   // with the request present, and ready must rise at cycle 5.
   task automatic access0(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input string tag);
      bus0.mem_w_en_in   = wr;
      bus0.mem_r_en_in   = !wr;
      bus0.wb_en_in      = !wr;
      bus0.alu_result_in = addr;
      bus0.val_rm_in     = data;
      bus0.dest_in       = 4'd3;
      sram_oe0           = !wr;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         chk({tag, "_ready"}, bus0.ready, (c == 5) ? 32'd1 : 32'd0);
         chk({tag, "_addr"}, sram_addr0, exp_addr(addr, (c >= 3)));
         chk({tag, "_we_n"}, sram_we_n0, (wr && (c == 1 || c == 3)) ? 32'd0 : 32'd1);
         if (wr && c >= 1 && c <= 4)
            chk({tag, "_dq"}, sram_dq0, (c <= 2) ? data[15:0] : data[31:16]);
         if (!wr && c == 5)
            chk({tag, "_load"}, bus0.mem_result, exp_q.pop_front());
         if (c < 5) next_cycle();
      end
      next_cycle();
      idle0();
   endtask

   // ---------------- directed sequence
   initial begin
      logic [17:0] a_idle;
      rst      = 1'b0;
      mem_init = 1'b1;
      poke_en  = 1'b0;
      poke_idx = 6'd0;
      poke_val = 16'h0;
      dq3_val  = 16'h0;
      bus0.alu_result_in = 32'd1024;
      bus0.val_rm_in     = 32'h0;
      bus0.dest_in       = 4'd0;
      bus3.mem_r_en_in = 1'b0; bus3.mem_w_en_in = 1'b0; bus3.wb_en_in = 1'b0;
      bus3.alu_result_in = 32'd1024; bus3.val_rm_in = 32'h0; bus3.dest_in = 4'd0;
      idle0();
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_ready", bus0.ready, 32'd1);
      chk("rst_mem_result", bus0.mem_result, 32'h0);
      chk("rst_we_n", sram_we_n0, 32'd1);
      chk("rst_dq_released", sram_dq0, 32'h5A00);
      chk("rst_mem_result_w3", bus3.mem_result, 32'h0);
      rst = 1'b1;
      next_cycle();

      // Store 0xDEADBEEF to 1028, then load it back
      access0(1'b1, 32'd1028, 32'hDEADBEEF, "st1");
      chk("st1_lo_written", mem0[2], 32'hBEEF);
      chk("st1_hi_written", mem0[3], 32'hDEAD);
      chk("st1_keeps_result", bus0.mem_result, 32'h0);
      exp_q.push_back(32'hDEADBEEF);
      access0(1'b0, 32'd1028, 32'h0, "ld1");

      // Non-memory instruction: pure pass-through, no freeze, bus released
      bus0.wb_en_in = 1'b1; bus0.alu_result_in = 32'h12; bus0.dest_in = 4'hA;
      a_idle = exp_addr(32'h12, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("alu_ready", bus0.ready, 32'd1);
         chk("alu_wb_en_out", bus0.wb_en_out, 32'd1);
         chk("alu_result_out", bus0.alu_result_out, 32'h12);
         chk("alu_dest_out", bus0.dest_out, 32'hA);
         chk("alu_mem_r_en_out", bus0.mem_r_en_out, 32'd0);
         chk("alu_addr_idle", sram_addr0, a_idle);
         chk("alu_we_n", sram_we_n0, 32'd1);
         chk("alu_dq_released", sram_dq0, 16'h5A00 + 16'(a_idle[5:0]));
         chk("alu_result_held", bus0.mem_result, 32'hDEADBEEF);
         next_cycle();
      end
      idle0();

      // Reset asserted during WR_HI of a store to 1040 (halves at 8 and 9)
      bus0.mem_w_en_in = 1'b1; bus0.alu_result_in = 32'd1040; bus0.val_rm_in = 32'h12345678;
      sram_oe0 = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         if (c < 3) next_cycle();
      end
      chk("wrhi_we_n_low", sram_we_n0, 32'd0);
      chk("wrhi_addr", sram_addr0, 32'd9);
      rst = 1'b0;
      sram_oe0 = 1'b1;
      #1;
      chk("midrst_we_n", sram_we_n0, 32'd1);
      chk("midrst_addr_idle", sram_addr0, 32'd8);
      chk("midrst_dq_released", sram_dq0, 32'h5678);
      chk("midrst_mem_result", bus0.mem_result, 32'h0);
      chk("midrst_ready", bus0.ready, 32'd0);
      chk("midrst_hi_unwritten", mem0[9], 32'h5A09);
      next_cycle();
      rst = 1'b1;
      idle0();
      next_cycle();
      access0(1'b1, 32'd1040, 32'hA5A50F0F, "st2");
      chk("st2_lo_written", mem0[8], 32'h0F0F);
      chk("st2_hi_written", mem0[9], 32'hA5A5);

      // Store 0x0000CAFE to 1032, then corrupt the SRAM copy behind the stage's back
      access0(1'b1, 32'd1032, 32'h0000CAFE, "st3");
      poke_en = 1'b1; poke_idx = 6'd4; poke_val = 16'hBAD0;
      next_cycle();
      poke_idx = 6'd5; poke_val = 16'hBAD1;
      next_cycle();
      poke_en = 1'b0;
`ifdef SRAM_LAST_WORD_CACHE_EN
      // A hit completes from the cache: one cycle low, no SRAM data used
      exp_q.push_back(32'h0000CAFE);
      bus0.mem_r_en_in = 1'b1; bus0.wb_en_in = 1'b1; bus0.alu_result_in = 32'd1032;
      @(negedge clk);
      chk("hit_ready_c0", bus0.ready, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("hit_ready_c1", bus0.ready, 32'd1);
      chk("hit_we_n", sram_we_n0, 32'd1);
      chk("hit_load", bus0.mem_result, exp_q.pop_front());
      next_cycle();
      idle0();
`else
      // Without the cache the load reads whatever the SRAM now holds
      exp_q.push_back({16'hBAD1, 16'hBAD0});
      access0(1'b0, 32'd1032, 32'h0, "ld3");
`endif
      // A different word always takes the full SRAM sequence
      exp_q.push_back({16'h5A07, 16'h5A06});
      access0(1'b0, 32'd1036, 32'h0, "ld4");

      // WAIT_CYCLES=3: 9 low cycles. The bench drives valid data only on the
      // 4th cycle of each half, so an early or late sample picks up a decoy.
      bus3.mem_r_en_in = 1'b1; bus3.wb_en_in = 1'b1; bus3.alu_result_in = 32'd1024;
      exp_q.push_back(32'h22221111);
      for (int c = 0; c <= 9; c++) begin
         dq3_val = (c == 4) ? 16'h1111 : (c == 8) ? 16'h2222 : (16'hEE00 | 16'(c));
         @(negedge clk);
         chk("w3_ready", bus3.ready, (c == 9) ? 32'd1 : 32'd0);
         chk("w3_addr", sram_addr3, (c <= 4) ? 32'd0 : 32'd1);
         chk("w3_we_n", sram_we_n3, 32'd1);
         if (c == 9) chk("w3_load", bus3.mem_result, exp_q.pop_front());
         if (c < 9) next_cycle();
      end
      next_cycle();
      bus3.mem_r_en_in = 1'b0;
      @(negedge clk);
      chk("w3_ready_after", bus3.ready, 32'd1);
      chk("w3_wb_en_out", bus3.wb_en_out, 32'd1);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
